// File: rtl/mic_fire_pkg.sv
// Shared types and constants for the mic-to-fire detector.
// State encodings double as the state_dbg output value.
package mic_fire_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRING  = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam int SAMPLE_MSB = 31;
    localparam int SAMPLE_LSB = 16;
    localparam int ENV_W      = 16;

endpackage

// File: rtl/envelope_follower.sv
// Rectify, saturate and leaky-integrate the upper half of each mic sample.
// One sample per clock in, env/env_valid two clocks later.
module envelope_follower
    import mic_fire_pkg::*;
#(
    parameter int DECAY_SHIFT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [15:0]      sample_i,
    output logic [ENV_W-1:0] env_o,
    output logic             env_valid_o
);

    logic signed [15:0] s;
    logic [14:0]        abs_d, abs_q;
    logic               abs_vld_q;
    logic signed [17:0] cur, diff, sum;
    logic [ENV_W-1:0]   env_d, env_q;
    logic               env_vld_q;

    assign s = sample_i;

    // -32768 has no positive twin in 16 bits, so pin it to full scale
    always_comb begin
        abs_d = s[14:0];
        if (sample_i == 16'h8000) begin
            abs_d = 15'h7FFF;
        end else if (s[15]) begin
            abs_d = 15'(-s);
        end
    end

    assign cur  = $signed({2'b00, env_q});
    assign diff = $signed({3'b000, abs_q}) - cur;
    assign sum  = cur + (diff >>> DECAY_SHIFT);

    always_comb begin
        env_d = sum[15:0];
        if (sum[17]) begin
            env_d = '0;
        end else if (sum[16]) begin
            env_d = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            abs_q     <= '0;
            abs_vld_q <= 1'b0;
            env_q     <= '0;
            env_vld_q <= 1'b0;
        end else begin
            abs_vld_q <= valid_i;
            env_vld_q <= abs_vld_q;
            if (valid_i) begin
                abs_q <= abs_d;
            end
            if (abs_vld_q) begin
                env_q <= env_d;
            end
        end
    end

    assign env_o       = env_q;
    assign env_valid_o = env_vld_q;

endmodule

// File: rtl/mic_fire_detector.sv
// Turns left-channel mic loudness into the game fire level and a start pulse.
// Envelope threshold with qualify count, hysteresis and refire holdoff.
module mic_fire_detector
    import mic_fire_pkg::*;
#(
    parameter int          DECAY_SHIFT    = 4,
    parameter logic [15:0] ON_THRESH      = 16'h2000,
    parameter logic [15:0] OFF_THRESH     = 16'h1000,
    parameter int          MIN_SAMPLES    = 4,
    parameter int          HOLDOFF_CYCLES = 5_000_000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    output logic        read_audio_in,
    output logic        fire,
    output logic        fire_pulse,
    output logic [7:0]  level,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0]  MIN_W     = 4'(MIN_SAMPLES);
    localparam logic [23:0] HOLD_LOAD = 24'(HOLDOFF_CYCLES - 1);

    logic [15:0]      smp_q;
    logic             smp_vld_q;
    logic [ENV_W-1:0] env;
    logic             env_vld;
    logic             loud, quiet;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] hold_q, hold_d;
    logic        fire_q, pulse_q;

    assign read_audio_in = audio_in_available & enable & resetn;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            smp_q     <= '0;
            smp_vld_q <= 1'b0;
        end else begin
            smp_vld_q <= read_audio_in;
            if (read_audio_in) begin
                smp_q <= left_channel_audio_in[SAMPLE_MSB:SAMPLE_LSB];
            end
        end
    end

    envelope_follower #(
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_env (
        .clk_i      (CLOCK_50),
        .rst_ni     (resetn),
        .valid_i    (smp_vld_q),
        .sample_i   (smp_q),
        .env_o      (env),
        .env_valid_o(env_vld)
    );

    assign loud  = env >= ON_THRESH;
    assign quiet = env < OFF_THRESH;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (env_vld && loud) begin
                    cnt_d   = 4'd1;
                    state_d = (MIN_W == 4'd1) ? FIRING : ARMED;
                end
            end
            ARMED: begin
                if (env_vld) begin
                    if (loud) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == MIN_W) begin
                            state_d = FIRING;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            FIRING: begin
                cnt_d = '0;
                if (env_vld && quiet) begin
                    hold_d  = HOLD_LOAD;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // lockout runs on the clock, not on samples
                cnt_d = '0;
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            fire_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fire_q  <= state_d == FIRING;
            pulse_q <= (state_d == FIRING) && (state_q != FIRING);
        end
    end

    assign fire       = fire_q;
    assign fire_pulse = pulse_q;
    assign level      = env[15:8];
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mic_fire_detector.sv
// Bench for mic_fire_detector: two instances (DECAY_SHIFT 4 and 0)
// share stimulus and are checked every cycle against a sample-level model.
module tb_mic_fire_detector;

    localparam int HOLD = 100;
    localparam int MINS = 4;
    localparam int ON   = 16'h2000;
    localparam int OFF  = 16'h1000;

    logic        clk = 1'b0;
    logic        rstn, en, avail;
    logic [31:0] data;

    logic       rd_a, fire_a, pulse_a;
    logic [7:0] level_a;
    logic [1:0] state_a;
    logic       rd_b, fire_b, pulse_b;
    logic [7:0] level_b;
    logic [1:0] state_b;

    always #5 clk = ~clk;

    mic_fire_detector #(
        .DECAY_SHIFT(4), .MIN_SAMPLES(MINS), .HOLDOFF_CYCLES(HOLD)
    ) u_a (
        .CLOCK_50(clk), .resetn(rstn), .enable(en),
        .audio_in_available(avail), .left_channel_audio_in(data),
        .read_audio_in(rd_a), .fire(fire_a), .fire_pulse(pulse_a),
        .level(level_a), .state_dbg(state_a)
    );

    mic_fire_detector #(
        .DECAY_SHIFT(0), .MIN_SAMPLES(MINS), .HOLDOFF_CYCLES(HOLD)
    ) u_b (
        .CLOCK_50(clk), .resetn(rstn), .enable(en),
        .audio_in_available(avail), .left_channel_audio_in(data),
        .read_audio_in(rd_b), .fire(fire_b), .fire_pulse(pulse_b),
        .level(level_b), .state_dbg(state_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // sample-level reference: one entry per accepted sample
    typedef struct {
        int due;
        int ab;
    } acc_t;

    acc_t aq[$];
    int   m_env[2], m_st[2], m_cnt[2], m_h[2];
    bit   m_pulse[2];
    bit   upd_prev;
    int   cyc = 0;

    int pc_a, pc_b, pops, offers;
    int first_pulse_a, first_pulse_b, last_pulse_b, fall_b;
    bit prev_fire_b, saw_armed_b;

    function automatic int sat_abs(input logic [31:0] d);
        logic signed [15:0] h;
        int s;
        h = d[31:16];
        s = h;
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    task automatic model_reset();
        aq.delete();
        upd_prev = 0;
        for (int i = 0; i < 2; i++) begin
            m_env[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_h[i] = 0;
            m_pulse[i] = 0;
        end
    endtask

    task automatic model_eval(input int i);
        int e;
        e = m_env[i];
        case (m_st[i])
            0: if (e >= ON) begin
                m_cnt[i] = 1;
                m_st[i]  = (MINS == 1) ? 2 : 1;
            end
            1: if (e >= ON) begin
                m_cnt[i]++;
                if (m_cnt[i] == MINS) begin
                    m_st[i]  = 2;
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
                m_st[i]  = 0;
            end
            2: if (e < OFF) begin
                m_st[i] = 3;
                m_h[i]  = HOLD - 1;
            end
            default: ;
        endcase
    endtask

    task automatic model_edge(input bit acc, input logic [31:0] d);
        int   prev, sh, v;
        acc_t a;
        for (int i = 0; i < 2; i++) begin
            prev = m_st[i];
            if (m_st[i] == 3) begin
                if (m_h[i] == 0) m_st[i] = 0;
                else m_h[i]--;
            end else if (upd_prev) begin
                model_eval(i);
            end
            m_pulse[i] = (m_st[i] == 2) && (prev != 2);
        end
        upd_prev = 0;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            a = aq.pop_front();
            for (int i = 0; i < 2; i++) begin
                sh = (i == 0) ? 4 : 0;
                v  = m_env[i] + ((a.ab - m_env[i]) >>> sh);
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
                m_env[i] = v;
            end
            upd_prev = 1;
        end
        if (acc) begin
            a.due = cyc + 2;
            a.ab  = sat_abs(d);
            aq.push_back(a);
        end
    endtask

    task automatic check_outs();
        chk("fire_a", fire_a, m_st[0] == 2);
        chk("pulse_a", pulse_a, m_pulse[0]);
        chk("level_a", level_a, m_env[0] >> 8);
        chk("state_a", state_a, m_st[0]);
        chk("fire_b", fire_b, m_st[1] == 2);
        chk("pulse_b", pulse_b, m_pulse[1]);
        chk("level_b", level_b, m_env[1] >> 8);
        chk("state_b", state_b, m_st[1]);
    endtask

    task automatic step(input bit av, input logic [31:0] d, input bit e);
        bit exp_rd, obs_rd;
        @(negedge clk);
        avail = av; data = d; en = e;
        #1;
        exp_rd = av & e & rstn;
        obs_rd = rd_a;
        chk("rd_a", rd_a, exp_rd);
        chk("rd_b", rd_b, exp_rd);
        if (obs_rd) pops++;
        if (av && e) offers++;
        @(posedge clk);
        cyc++;
        if (rstn) model_edge(exp_rd, d);
        else model_reset();
        #1;
        check_outs();
        pc_a += pulse_a;
        pc_b += pulse_b;
        if (pulse_a && first_pulse_a < 0) first_pulse_a = cyc;
        if (pulse_b && first_pulse_b < 0) first_pulse_b = cyc;
        if (pulse_b) last_pulse_b = cyc;
        if (prev_fire_b && !fire_b) fall_b = cyc;
        prev_fire_b = fire_b;
        if (state_b == 2'd1) saw_armed_b = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 32'h0, 1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rstn = 0;
        #1;
        chk("arst_fire_a", fire_a, 0);
        chk("arst_level_a", level_a, 0);
        chk("arst_state_a", state_a, 0);
        chk("arst_fire_b", fire_b, 0);
        chk("arst_level_b", level_b, 0);
        chk("arst_state_b", state_b, 0);
        chk("arst_rd", rd_a, 0);
        model_reset();
        prev_fire_b = 0;
    endtask

    // sample index (0-based) at which the MINS-th loud envelope appears
    function automatic int lat_index(input int sh, input int ab);
        int e, nl;
        e = 0; nl = 0;
        for (int j = 0; j < 40; j++) begin
            e = e + ((ab - e) >>> sh);
            if (e >= ON) begin
                nl++;
                if (nl == MINS) return j;
            end
        end
        return -1;
    endfunction

    initial begin
        int cyc0, j;
        rstn = 0; en = 0; avail = 0; data = 0;
        model_reset();
        pc_a = 0; pc_b = 0; pops = 0; offers = 0;
        first_pulse_a = -1; first_pulse_b = -1;
        last_pulse_b = -1; fall_b = -1;
        prev_fire_b = 0; saw_armed_b = 0;

        for (int k = 0; k < 3; k++) step(1, 32'h7FFF_0000, 1);
        rstn = 1;
        idle(3);

        // step response
        pc_a = 0; pc_b = 0; first_pulse_a = -1; first_pulse_b = -1;
        cyc0 = cyc;
        for (int k = 0; k < 40; k++) step(1, 32'h4000_0000, 1);
        j = lat_index(4, 16384);
        chk("step_lat_a", first_pulse_a, cyc0 + 1 + j + 3);
        j = lat_index(0, 16384);
        chk("step_lat_b", first_pulse_b, cyc0 + 1 + j + 3);
        for (int k = 0; k < 60; k++) step(1, 32'h0, 1);
        idle(120);
        chk("step_pulses_a", pc_a, 1);
        chk("step_pulses_b", pc_b, 1);
        chk("step_idle_b", state_b, 0);

        // short burst must not qualify
        pc_a = 0; pc_b = 0; saw_armed_b = 0;
        for (int k = 0; k < 3; k++) step(1, 32'h7FFF_0000, 1);
        for (int k = 0; k < 10; k++) step(1, 32'h0, 1);
        idle(5);
        chk("burst_pulses_b", pc_b, 0);
        chk("burst_pulses_a", pc_a, 0);
        chk("burst_armed_b", saw_armed_b, 1);
        chk("burst_idle_b", state_b, 0);

        // reset while firing
        for (int k = 0; k < 8; k++) step(1, 32'h7FFF_0000, 1);
        chk("pre_rst_fire_b", fire_b, 1);
        async_reset();
        for (int k = 0; k < 3; k++) step(1, 32'h7FFF_0000, 1);
        rstn = 1;
        pc_a = 0; pc_b = 0;
        for (int k = 0; k < 20; k++) step(1, 32'h0, 1);
        chk("rst_rel_pulses_a", pc_a, 0);
        chk("rst_rel_pulses_b", pc_b, 0);

        // hysteresis, holdoff and refire
        for (int k = 0; k < 6; k++) step(1, 32'h7FFF_0000, 1);
        idle(3);
        chk("hyst_fire_on_b", fire_b, 1);
        for (int k = 0; k < 10; k++) step(1, 32'h1800_0000, 1);
        idle(3);
        chk("hyst_fire_mid_b", fire_b, 1);
        fall_b = -1;
        step(1, 32'h0, 1);
        for (int k = 0; k < 20 && fall_b < 0; k++) idle(1);
        chk("hyst_fall_seen_b", fall_b >= 0, 1);
        while (fall_b >= 0 && cyc < fall_b + 49) idle(1);
        pc_b = 0; last_pulse_b = -1;
        for (int k = 0; k < 80; k++) step(1, 32'h7FFF_0000, 1);
        idle(10);
        chk("refire_pulses_b", pc_b, 1);
        chk("refire_gap_b", last_pulse_b - fall_b, HOLD + MINS);

        // most negative sample saturates
        for (int k = 0; k < 20; k++) step(1, 32'h8000_0000, 1);
        idle(3);
        chk("sat_level_b", level_b, 8'h7F);
        chk("sat_level_a_le", level_a <= 8'h7F, 1);

        // random flow control with an enable gap
        pops = 0; offers = 0;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] d;
            d = ($urandom_range(2) == 0) ? ($urandom | 32'h7000_0000)
                                         : $urandom;
            step(bit'($urandom_range(1)), d, !(k >= 100 && k < 120));
        end
        idle(150);
        chk("flow_pops", pops, offers);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
